store_merge_unit: RTL and testbench

STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

---
 rtl/store_merge_unit.sv | 139 +++++++++++++
 tb/tb_store_merge_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_merge_unit.sv
// Read-modify-write engine for byte/halfword stores into a word-wide memory.
// Full-word stores bypass the read; misaligned stores are rejected with a pulse.
module store_merge_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        req_ready,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        err_misaligned
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_SB   = 2'b01,
    OP_SH   = 2'b10,
    OP_SW   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    MERGE,
    WRITE
  } state_e;

  state_e      state_q;
  op_e         op_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [31:0] rdata_q;
  logic [31:0] wdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        done_q;
  logic        err_q;

  logic [31:0] merged_d;
  logic        misaligned_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    merged_d = rdata_q;
    unique case (op_q)
      OP_SB:   merged_d[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
      OP_SH:   merged_d[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
      OP_SW:   merged_d = data_q;
      default: merged_d = rdata_q;
    endcase
  end

  always_comb begin
    misaligned_d = 1'b0;
    if (op_e'(req_op) == OP_SH) misaligned_d = req_addr[0];
    if (op_e'(req_op) == OP_SW) misaligned_d = (req_addr[1:0] != 2'b00);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_NONE;
      addr_q      <= '0;
      data_q      <= '0;
      rdata_q     <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else if (clk_enable) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid && op_e'(req_op) != OP_NONE) begin
            if (misaligned_d) begin
              err_q <= 1'b1;
            end else begin
              op_q   <= op_e'(req_op);
              addr_q <= req_addr;
              data_q <= req_data;
              if (op_e'(req_op) == OP_SW) begin
                wdata_q     <= req_data;
                mem_write_q <= 1'b1;
                state_q     <= WRITE;
              end else begin
                mem_read_q <= 1'b1;
                state_q    <= READ;
              end
            end
          end
        end
        READ: begin
          if (!mem_waitrequest) begin
            rdata_q    <= mem_readdata;
            mem_read_q <= 1'b0;
            state_q    <= MERGE;
          end
        end
        MERGE: begin
          wdata_q     <= merged_d;
          mem_write_q <= 1'b1;
          state_q     <= WRITE;
        end
        WRITE: begin
          if (!mem_waitrequest) begin
            mem_write_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE) && clk_enable && reset;
  assign busy           = (state_q != IDLE);
  assign mem_address    = {addr_q[31:2], 2'b00};
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = wdata_q;
  assign done           = done_q;
  assign err_misaligned = err_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: expected writes are queued at issue time
// and matched by a monitor when the memory accepts each write.
module tb_store_merge_unit;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_SB   = 2'b01;
  localparam logic [1:0] OP_SH   = 2'b10;
  localparam logic [1:0] OP_SW   = 2'b11;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        req_ready;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_waitrequest;
  logic        busy;
  logic        done;
  logic        err_misaligned;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int rd_cnt   = 0;
  int wr_cnt   = 0;
  wr_t exp_q[$];

  store_merge_unit dut (
    .clk             (clk),
    .reset           (reset),
    .clk_enable      (clk_enable),
    .req_valid       (req_valid),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_writedata   (mem_writedata),
    .mem_readdata    (mem_readdata),
    .mem_waitrequest (mem_waitrequest),
    .busy            (busy),
    .done            (done),
    .err_misaligned  (err_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_data  = data;
    step();
    req_valid = 1'b0;
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Scoreboard side: a write completes on the edge after a cycle with
  // mem_write high, waitrequest low, enable high and reset released.
  always @(negedge clk) begin
    wr_t e;
    if (reset) check("rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
    if (reset && clk_enable && mem_read)  rd_cnt++;
    if (reset && clk_enable && mem_write) wr_cnt++;
    if (reset && clk_enable && done)      done_cnt++;
    if (reset && clk_enable && mem_write && !mem_waitrequest) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", mem_address, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("sb_wr_addr", mem_address, e.addr);
        check("sb_wr_data", mem_writedata, e.data);
      end
    end
  end

  initial begin
    int d0;
    int r0;
    int w0;
    reset = 1'b0; clk_enable = 1'b1; req_valid = 1'b0; req_op = OP_NONE;
    req_addr = '0; req_data = '0; mem_readdata = '0; mem_waitrequest = 1'b0;
    step(); step();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err_misaligned}, 0);
    check("rst_rd", {31'b0, mem_read}, 0);
    check("rst_wr", {31'b0, mem_write}, 0);
    check("rst_wdata", mem_writedata, 0);
    check("rst_addr", mem_address, 0);
    check("rst_ready_low", {31'b0, req_ready}, 0);
    reset = 1'b1;
    #1;
    check("ready_after_rst", {31'b0, req_ready}, 1);

    // sb lane 2, zero wait, with junk on req_* while busy
    mem_readdata = 32'h1122_3344;
    expect_write(32'h0000_1000, 32'h11AB_3344);
    issue(OP_SB, 32'h0000_1002, 32'h0000_00AB);
    check("sb_c1_rd", {31'b0, mem_read}, 1);
    check("sb_c1_wr", {31'b0, mem_write}, 0);
    check("sb_c1_busy", {31'b0, busy}, 1);
    check("sb_c1_ready", {31'b0, req_ready}, 0);
    check("sb_c1_addr", mem_address, 32'h0000_1000);
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h0000_3000; req_data = 32'hFFFF_FFFF;
    step();
    mem_readdata = 32'hFFFF_FFFF;
    check("sb_c2_rd", {31'b0, mem_read}, 0);
    check("sb_c2_wr", {31'b0, mem_write}, 0);
    check("sb_c2_busy", {31'b0, busy}, 1);
    step();
    req_valid = 1'b0;
    check("sb_c3_wr", {31'b0, mem_write}, 1);
    check("sb_c3_wdata", mem_writedata, 32'h11AB_3344);
    check("sb_c3_addr", mem_address, 32'h0000_1000);
    step();
    check("sb_c4_done", {31'b0, done}, 1);
    check("sb_c4_ready", {31'b0, req_ready}, 1);
    check("sb_c4_busy", {31'b0, busy}, 0);
    step();
    check("sb_c5_done", {31'b0, done}, 0);

    // sh upper half with two wait cycles in READ and in WRITE
    mem_readdata = 32'h1122_3344;
    mem_waitrequest = 1'b1;
    expect_write(32'h0000_1000, 32'hBEEF_3344);
    issue(OP_SH, 32'h0000_1002, 32'h0000_BEEF);
    check("sh_c1_rd", {31'b0, mem_read}, 1);
    step();
    check("sh_c2_rd", {31'b0, mem_read}, 1);
    step();
    mem_waitrequest = 1'b0;
    check("sh_c3_rd", {31'b0, mem_read}, 1);
    step();
    mem_waitrequest = 1'b1;
    mem_readdata = 32'h0;
    check("sh_merge_rd", {31'b0, mem_read}, 0);
    check("sh_merge_wr", {31'b0, mem_write}, 0);
    step();
    d0 = done_cnt;
    check("sh_c5_wr", {31'b0, mem_write}, 1);
    check("sh_c5_wdata", mem_writedata, 32'hBEEF_3344);
    check("sh_c5_addr", mem_address, 32'h0000_1000);
    step();
    check("sh_c6_wr", {31'b0, mem_write}, 1);
    check("sh_c6_done", {31'b0, done}, 0);
    step();
    mem_waitrequest = 1'b0;
    check("sh_c7_wr", {31'b0, mem_write}, 1);
    step();
    check("sh_done", {31'b0, done}, 1);
    step();
    check("sh_done_clear", {31'b0, done}, 0);
    check("sh_done_once", done_cnt - d0, 1);

    // sw bypass, then back-to-back sw accepted in the done cycle
    r0 = rd_cnt;
    expect_write(32'h0000_2000, 32'hDEAD_BEEF);
    issue(OP_SW, 32'h0000_2000, 32'hDEAD_BEEF);
    check("sw_c1_wr", {31'b0, mem_write}, 1);
    check("sw_c1_rd", {31'b0, mem_read}, 0);
    check("sw_c1_wdata", mem_writedata, 32'hDEAD_BEEF);
    check("sw_c1_addr", mem_address, 32'h0000_2000);
    step();
    check("sw_c2_done", {31'b0, done}, 1);
    check("sw_c2_ready", {31'b0, req_ready}, 1);
    expect_write(32'h0000_2004, 32'h1234_5678);
    issue(OP_SW, 32'h0000_2004, 32'h1234_5678);
    check("b2b_wr", {31'b0, mem_write}, 1);
    check("b2b_wdata", mem_writedata, 32'h1234_5678);
    check("b2b_done_clear", {31'b0, done}, 0);
    step();
    check("b2b_done", {31'b0, done}, 1);
    step();
    check("sw_no_read", rd_cnt - r0, 0);

    // misaligned sh / sw and ignored op 00
    r0 = rd_cnt;
    w0 = wr_cnt;
    check("mis_ready_pre", {31'b0, req_ready}, 1);
    issue(OP_SH, 32'h0000_1001, 32'h0000_1234);
    check("mis_sh_err", {31'b0, err_misaligned}, 1);
    check("mis_sh_busy", {31'b0, busy}, 0);
    check("mis_sh_ready", {31'b0, req_ready}, 1);
    check("mis_sh_rd", {31'b0, mem_read}, 0);
    check("mis_sh_wr", {31'b0, mem_write}, 0);
    step();
    check("mis_sh_err_clear", {31'b0, err_misaligned}, 0);
    issue(OP_SW, 32'h0000_2002, 32'h0000_5678);
    check("mis_sw_err", {31'b0, err_misaligned}, 1);
    check("mis_sw_busy", {31'b0, busy}, 0);
    step();
    issue(OP_NONE, 32'h0000_1001, 32'h0000_9999);
    check("nop_err", {31'b0, err_misaligned}, 0);
    check("nop_busy", {31'b0, busy}, 0);
    step();
    check("mis_no_read", rd_cnt - r0, 0);
    check("mis_no_write", wr_cnt - w0, 0);

    // reset during a stalled WRITE aborts without a done pulse
    mem_waitrequest = 1'b1;
    issue(OP_SW, 32'h0000_4000, 32'h0000_0055);
    check("abort_wr_pre", {31'b0, mem_write}, 1);
    reset = 1'b0;
    step();
    check("abort_wr", {31'b0, mem_write}, 0);
    check("abort_busy", {31'b0, busy}, 0);
    check("abort_done", {31'b0, done}, 0);
    check("abort_wdata", mem_writedata, 0);
    reset = 1'b1;
    mem_waitrequest = 1'b0;
    d0 = done_cnt;
    step(); step();
    check("abort_no_done", done_cnt - d0, 0);

    // clk_enable low for three cycles in READ, then in the done cycle
    mem_readdata = 32'hAABB_CCDD;
    expect_write(32'h0000_5000, 32'h77BB_CCDD);
    issue(OP_SB, 32'h0000_5003, 32'h0000_0077);
    clk_enable = 1'b0;
    #1;
    check("frz_ready", {31'b0, req_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_rd", {31'b0, mem_read}, 1);
      check("frz_busy", {31'b0, busy}, 1);
      check("frz_addr", mem_address, 32'h0000_5000);
    end
    clk_enable = 1'b1;
    step();
    check("frz_merge_rd", {31'b0, mem_read}, 0);
    step();
    check("frz_wdata", mem_writedata, 32'h77BB_CCDD);
    step();
    check("frz_done", {31'b0, done}, 1);
    clk_enable = 1'b0;
    step();
    check("frz_done_held", {31'b0, done}, 1);
    clk_enable = 1'b1;
    step();
    check("frz_done_clear", {31'b0, done}, 0);

    // reset wins over clk_enable=0
    mem_waitrequest = 1'b1;
    issue(OP_SW, 32'h0000_6000, 32'h0000_0001);
    clk_enable = 1'b0;
    reset = 1'b0;
    step();
    check("rst_pri_busy", {31'b0, busy}, 0);
    check("rst_pri_wr", {31'b0, mem_write}, 0);
    reset = 1'b1;
    clk_enable = 1'b1;
    mem_waitrequest = 1'b0;
    step();
    check("rst_pri_done", {31'b0, done}, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
